// File: rtl/red_seq_pkg.sv
// Shared types and constants for the RED reduction sequencer.
// Step order: L0/L1 (low byte), U0/U1 (high byte), F0..F2 (12-bit final add).
package red_seq_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        L0   = 4'd1,
        L1   = 4'd2,
        U0   = 4'd3,
        U1   = 4'd4,
        F0   = 4'd5,
        F1   = 4'd6,
        F2   = 4'd7,
        DONE = 4'd8
    } red_state_t;

    localparam int RED_STEPS = 7;
    localparam int RED_LAT   = 8;

    localparam int NIB_W    = 4;
    localparam int NIB0_LSB = 0;
    localparam int NIB1_LSB = 4;
    localparam int NIB2_LSB = 8;
    localparam int NIB3_LSB = 12;

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder/subtractor with optional unsigned saturation.
// Pure combinational; sub inverts b and forces carry-in.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    input  logic       sat,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] bb;
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic [3:0] raw;

    assign bb   = b ^ {4{sub}};
    assign g    = a & bb;
    assign p    = a ^ bb;
    assign c[0] = cin | sub;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign raw  = p ^ c;

    // Saturation: clamp to 0 on borrow when subtracting, to 0xF on carry when adding.
    always_comb begin
        sum = raw;
        if (sat) begin
            if (sub) sum = cout ? raw : 4'h0;
            else     sum = cout ? 4'hF : raw;
        end
    end

endmodule

// File: rtl/red_opnd_mux.sv
// Per-state operand and carry-in selection for the shared CLA.
// Combinational; IDLE and DONE drive zeros.
module red_opnd_mux
    import red_seq_pkg::*;
(
    input  red_state_t  state,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic [7:0]  lo_sum,
    input  logic [7:0]  hi_sum,
    input  logic        lo_c,
    input  logic        hi_c,
    input  logic        cy,
    output logic [3:0]  a,
    output logic [3:0]  b,
    output logic        cin
);

    always_comb begin
        a   = 4'h0;
        b   = 4'h0;
        cin = 1'b0;
        case (state)
            L0: begin a = opa[NIB0_LSB +: NIB_W]; b = opb[NIB0_LSB +: NIB_W]; end
            L1: begin a = opa[NIB1_LSB +: NIB_W]; b = opb[NIB1_LSB +: NIB_W]; cin = cy; end
            U0: begin a = opa[NIB2_LSB +: NIB_W]; b = opb[NIB2_LSB +: NIB_W]; end
            U1: begin a = opa[NIB3_LSB +: NIB_W]; b = opb[NIB3_LSB +: NIB_W]; cin = cy; end
            F0: begin a = lo_sum[NIB0_LSB +: NIB_W]; b = hi_sum[NIB0_LSB +: NIB_W]; end
            F1: begin a = lo_sum[NIB1_LSB +: NIB_W]; b = hi_sum[NIB1_LSB +: NIB_W]; cin = cy; end
            // Top nibble of each 12-bit operand is its byte carry replicated (sign extension).
            F2: begin a = {NIB_W{lo_c}}; b = {NIB_W{hi_c}}; cin = cy; end
            default: ;
        endcase
    end

endmodule

// File: rtl/red_seq.sv
// RED sequencer: sums the two byte-wise sums of A+B through one shared 4-bit CLA over 7 steps.
// Result valid 8 cycles after start; stall holds the pipeline from the start cycle until DONE.
module red_seq
    import red_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [15:0] Out
);

    red_state_t  state;
    red_state_t  state_nxt;
    logic        accept;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [7:0]  lo_sum;
    logic [7:0]  hi_sum;
    logic [7:0]  f_sum;
    logic        lo_c;
    logic        hi_c;
    logic        cy;
    logic [3:0]  cla_a;
    logic [3:0]  cla_b;
    logic        cla_cin;
    logic [3:0]  cla_sum;
    logic        cla_cout;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = start ? L0 : IDLE;
                L0:      state_nxt = L1;
                L1:      state_nxt = U0;
                U0:      state_nxt = U1;
                U1:      state_nxt = F0;
                F0:      state_nxt = F1;
                F1:      state_nxt = F2;
                F2:      state_nxt = DONE;
                DONE:    state_nxt = start ? L0 : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // flush drops a coincident start, and nothing is accepted while reset is held.
    always_comb begin
        busy   = (state != IDLE) && (state != DONE);
        done   = (state == DONE);
        accept = rst_n && !flush && start && ((state == IDLE) || (state == DONE));
        stall  = rst_n && (busy || accept);
    end

    red_opnd_mux u_mux (
        .state  (state),
        .opa    (opa),
        .opb    (opb),
        .lo_sum (lo_sum),
        .hi_sum (hi_sum),
        .lo_c   (lo_c),
        .hi_c   (hi_c),
        .cy     (cy),
        .a      (cla_a),
        .b      (cla_b),
        .cin    (cla_cin)
    );

    cla_4bit u_cla (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (cla_cin),
        .sub  (1'b0),
        .sat  (1'b0),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa    <= 16'h0;
            opb    <= 16'h0;
            lo_sum <= 8'h0;
            hi_sum <= 8'h0;
            f_sum  <= 8'h0;
            lo_c   <= 1'b0;
            hi_c   <= 1'b0;
            cy     <= 1'b0;
            Out    <= 16'h0;
        end else if (flush) begin
            lo_sum <= 8'h0;
            hi_sum <= 8'h0;
            f_sum  <= 8'h0;
            lo_c   <= 1'b0;
            hi_c   <= 1'b0;
            cy     <= 1'b0;
        end else begin
            if (accept) begin
                opa <= A;
                opb <= B;
            end
            case (state)
                L0: begin lo_sum[3:0] <= cla_sum; cy <= cla_cout; end
                L1: begin lo_sum[7:4] <= cla_sum; lo_c <= cla_cout; end
                U0: begin hi_sum[3:0] <= cla_sum; cy <= cla_cout; end
                U1: begin hi_sum[7:4] <= cla_sum; hi_c <= cla_cout; end
                F0: begin f_sum[3:0] <= cla_sum; cy <= cla_cout; end
                F1: begin f_sum[7:4] <= cla_sum; cy <= cla_cout; end
                // Final carry is bit 12 of the 13-bit sum; replicate it into bits 15:12.
                F2: Out <= {{4{cla_cout}}, cla_sum, f_sum};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_red_seq.sv
// Directed-vector bench for red_seq; inputs change 1ns after posedge, outputs sampled on negedge.
module tb_red_seq;
    import red_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        stall;
    logic        done;
    logic [15:0] Out;

    int n_cmp = 0;
    int n_err = 0;

    red_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .flush (flush),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .Out   (Out)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; A = 16'h0; B = 16'h0;
        next_cycle();
        start = 1'b1;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (stall !== 1'b0)  begin n_err++; $display("FAIL reset_stall got %b want 0", stall); end
        n_cmp++; if (Out !== 16'h0)   begin n_err++; $display("FAIL reset_out got %h want 0000", Out); end
        next_cycle();
        start = 1'b0; rst_n = 1'b1;
        next_cycle();
    endtask

    // Operands scrambled after the start cycle must not affect the result.
    task automatic test_basic();
        A = 16'h0102; B = 16'h0304; start = 1'b1;
        for (int c = 0; c <= RED_LAT; c++) begin
            @(negedge clk);
            n_cmp++; if (stall !== (c < RED_LAT)) begin n_err++; $display("FAIL basic_stall c=%0d got %b want %b", c, stall, c < RED_LAT); end
            n_cmp++; if (done !== (c == RED_LAT)) begin n_err++; $display("FAIL basic_done c=%0d got %b want %b", c, done, c == RED_LAT); end
            if (c == RED_LAT) begin
                n_cmp++; if (Out !== 16'h000A) begin n_err++; $display("FAIL basic_out got %h want 000a", Out); end
            end
            next_cycle();
            start = 1'b0; A = 16'hFFFF; B = 16'hFFFF;
        end
    endtask

    task automatic test_carries();
        A = 16'hFF80; B = 16'hFF80; start = 1'b1;
        for (int c = 0; c <= RED_LAT; c++) begin
            @(negedge clk);
            if (c == 4) begin
                n_cmp++; if (Out !== 16'h000A) begin n_err++; $display("FAIL carries_hold got %h want 000a", Out); end
            end
            if (c == RED_LAT) begin
                n_cmp++; if (done !== 1'b1)    begin n_err++; $display("FAIL carries_done got %b want 1", done); end
                n_cmp++; if (Out !== 16'hFEFE) begin n_err++; $display("FAIL carries_out got %h want fefe", Out); end
            end
            next_cycle();
            start = 1'b0; A = 16'h1234; B = 16'h5678;
        end
    endtask

    task automatic test_back_to_back();
        A = 16'h8000; B = 16'h8000; start = 1'b1;
        for (int c = 0; c <= 2 * RED_LAT; c++) begin
            @(negedge clk);
            if (c == RED_LAT) begin
                n_cmp++; if (done !== 1'b1)    begin n_err++; $display("FAIL b2b_done1 got %b want 1", done); end
                n_cmp++; if (Out !== 16'h0F00) begin n_err++; $display("FAIL b2b_out1 got %h want 0f00", Out); end
                n_cmp++; if (stall !== 1'b1)   begin n_err++; $display("FAIL b2b_stall_done got %b want 1", stall); end
            end
            if (c == RED_LAT + 1) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_no_idle got %b want 1", busy); end
            end
            if (c == 12) begin
                n_cmp++; if (Out !== 16'h0F00) begin n_err++; $display("FAIL b2b_hold got %h want 0f00", Out); end
            end
            if (c > RED_LAT && c < 2 * RED_LAT) begin
                n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_early_done c=%0d got %b want 0", c, done); end
            end
            if (c == 2 * RED_LAT) begin
                n_cmp++; if (done !== 1'b1)    begin n_err++; $display("FAIL b2b_done2 got %b want 1", done); end
                n_cmp++; if (Out !== 16'h0002) begin n_err++; $display("FAIL b2b_out2 got %h want 0002", Out); end
            end
            next_cycle();
            start = (c + 1 == RED_LAT);
            A = (c + 1 == RED_LAT) ? 16'h0001 : 16'hAAAA;
            B = (c + 1 == RED_LAT) ? 16'h0001 : 16'h5555;
        end
    endtask

    task automatic test_ignored_start();
        int dones = 0;
        A = 16'h0102; B = 16'h0304; start = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (c == 3) begin
                n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL ign_stall got %b want 1", stall); end
            end
            if (c == RED_LAT) begin
                n_cmp++; if (Out !== 16'h000A) begin n_err++; $display("FAIL ign_out got %h want 000a", Out); end
            end
            next_cycle();
            start = (c + 1 == 3);
            A = (c + 1 == 3) ? 16'h1234 : 16'h0000;
            B = (c + 1 == 3) ? 16'h4321 : 16'h0000;
        end
        n_cmp++; if (dones != 1) begin n_err++; $display("FAIL ign_done_count got %0d want 1", dones); end
    endtask

    task automatic test_flush();
        int dones = 0;
        A = 16'hFF80; B = 16'hFF80; start = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (c == 4) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_busy_before got %b want 1", busy); end
            end
            if (c == 5) begin
                n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL flush_idle got %b want 0", busy); end
                n_cmp++; if (Out !== 16'h000A) begin n_err++; $display("FAIL flush_out got %h want 000a", Out); end
            end
            next_cycle();
            start = 1'b0;
            flush = (c + 1 == 4);
        end
        n_cmp++; if (dones != 0) begin n_err++; $display("FAIL flush_done_count got %0d want 0", dones); end
        start = 1'b1; flush = 1'b1; A = 16'h7777; B = 16'h7777;
        next_cycle();
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_beats_start got %b want 0", busy); end
        next_cycle();
        A = 16'h0001; B = 16'h0002; start = 1'b1;
        for (int c = 0; c <= RED_LAT; c++) begin
            @(negedge clk);
            if (c == RED_LAT) begin
                n_cmp++; if (done !== 1'b1)    begin n_err++; $display("FAIL flush_after_done got %b want 1", done); end
                n_cmp++; if (Out !== 16'h0003) begin n_err++; $display("FAIL flush_after_out got %h want 0003", Out); end
            end
            next_cycle();
            start = 1'b0;
        end
    endtask

    task automatic test_reset_midop();
        A = 16'h0102; B = 16'h0304; start = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c == 5) begin
                n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall_low got %b want 0", stall); end
            end
            if (c == 6) begin
                n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL rst_mid_busy got %b want 0", busy); end
                n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL rst_mid_done got %b want 0", done); end
                n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall got %b want 0", stall); end
                n_cmp++; if (Out !== 16'h0)  begin n_err++; $display("FAIL rst_mid_out got %h want 0000", Out); end
            end
            next_cycle();
            start = (c + 1 >= 5);
            rst_n = !(c + 1 >= 5);
        end
        rst_n = 1'b1; start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_after c=%0d got done=%b busy=%b want 0/0", c, done, busy); end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carries();
        test_back_to_back();
        test_ignored_start();
        test_flush();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/red_seq.md
Name: red_seq

Overview:
Multi-cycle sequencer for the 16-bit RED (reduction) operation. It time-shares one cla_4bit adder across seven nibble steps instead of seven parallel adders. It sits in the EX stage beside the ALU, accepts a start pulse with operands, and stalls the pipeline until the result is ready.

Parameters:
none (widths fixed at 16 by the ISA; step count fixed at 7)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request a RED op; operands sampled same edge
flush  input  1  synchronous abort of any in-flight op
A  input  16  operand A
B  input  16  operand B
busy  output  1  op in progress (states L0..F2)
stall  output  1  combinational: busy | (start & accept)
done  output  1  one-cycle pulse, Out valid
Out  output  16  registered RED result, held until next completion

Behaviour:
- Arithmetic, all unsigned carry-chained:
  - lo9 = A[7:0] + B[7:0], a 9-bit value whose bit8 is the carry.
  - hi9 = A[15:8] + B[15:8], same form.
  - lo12 and hi12 = lo9 and hi9 sign-extended from bit8.
  - f13 = lo12 + hi12, a 13-bit value whose bit12 is the carry out of the 12-bit add.
  - Out = f13 sign-extended from bit12.
- States: IDLE, L0, L1, U0, U1, F0, F1, F2, DONE. One shared CLA op per step state:
  - L0: A[3:0]+B[3:0], cin=0
  - L1: A[7:4]+B[7:4], cin=carry of L0
  - U0: A[11:8]+B[11:8], cin=0
  - U1: A[15:12]+B[15:12], cin=carry of U0
  - F0: lo12[3:0]+hi12[3:0], cin=0
  - F1: next nibble, cin=carry of F0
  - F2: top nibble, cin=carry of F1
- The shared cla_4bit has sub=0 and sat=0. Operand muxing is selected by state. Carry and partial nibbles go to internal registers at each step edge.
- accept = start while in IDLE or DONE.
  - On accept: A and B are latched into operand registers, then next state = L0.
  - start while busy is ignored; no queueing, and stall remains high.
- Transitions:
  - L0 -> L1 -> U0 -> U1 -> F0 -> F1 -> F2 -> DONE, one per cycle, unconditionally.
  - DONE -> L0 if start, else -> IDLE.
  - IDLE stays in IDLE without start.
- Latency: start sampled in cycle 0, steps run in cycles 1..7, done=1 in cycle 8. Back-to-back ops give throughput of 1 op per 8 cycles.
- Out register loads at the F2->DONE edge only. It holds its value through IDLE and through subsequent ops until the next F2 edge.
- stall is combinational (busy | accept), so the pipeline freezes in the start cycle itself. stall = 0 in DONE unless a new start is accepted.
- flush=1: next state = IDLE and partial registers are cleared. Out keeps its old value and done is not pulsed. flush beats a simultaneous start; the start is dropped.
- rst_n=0 on a clock edge: state=IDLE, Out=0x0000, all partial and carry registers=0, busy=0, done=0. stall evaluates 0 while rst_n=0. Reset mid-op discards the op.
- Operand registers are not reloaded mid-op, so changes on A and B after the start cycle have no effect.

Decomposition:
- red_seq_pkg holds:
  - the state enum (IDLE, L0..F2, DONE)
  - RED_STEPS=7
  - RED_LAT=8
  - the nibble-select constants
- One sub-module, red_opnd_mux: combinational selection of CLA a/b/cin per state.
- A single cla_4bit instance is reused as-is.

Test Plan:
- A=0x0102, B=0x0304, start in cycle 0 -> stall=1 in cycles 0..7; done=1 only in cycle 8; Out=0x000A.
- A=0xFF80, B=0xFF80 -> Out=0xFEFE at done (both carries set, f13=0x1EFE).
- A=0x8000, B=0x8000 -> Out=0x0F00; then start held high in DONE with A=0x0001, B=0x0001 -> next done 8 cycles later, Out=0x0002, with no IDLE cycle between ops.
- start pulses again in cycle 3 with different operands -> ignored; result still from the first op; only one done pulse.
- flush in cycle 4 of an op with Out=0x000A held -> IDLE next cycle, no done, Out stays 0x000A; a new start then completes normally.
- rst_n=0 in cycle 5 of an op -> next cycle: state IDLE, Out=0x0000, busy=0, done=0, stall=0.
